// File: rtl/alu_iter_resp.sv
// alu_iter_resp: multi-cycle Y86 OPq ALU computing CHUNK_W-bit slices LSB first, with ZF/SF/OF.
// Optional ALU_FAST_LOGIC_EN: andq/xorq finish in a single compute cycle.
module alu_iter_resp #(
  parameter int CHUNK_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_ifun,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_zf,
  output logic        out_sf,
  output logic        out_of,
  output logic        out_err
);
  localparam int NCHUNK = 64 / CHUNK_W;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
`ifdef ALU_FAST_LOGIC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic [3:0] ifun_q, ifun_d;
  logic [63:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic zf_q, zf_d, sf_q, sf_d, of_q, of_d, err_q, err_d;
  logic [CHUNK_W-1:0] a_sl, b_sl, sum, slice;
  logic [63:0] full, res_f;
  logic co, cin, bad, add, sub, fast, last;
  assign bad  = ifun_q[3] | ifun_q[2];
  assign add  = ifun_q == 4'd0;
  assign sub  = ifun_q == 4'd1;
  assign fast = FAST && !bad && ifun_q[1];
  assign last = bad || fast || cnt_q == LAST;
  assign a_sl = a_q[cnt_q*CHUNK_W +: CHUNK_W];
  assign b_sl = b_q[cnt_q*CHUNK_W +: CHUNK_W];
  // subq is b + ~a + 1: the +1 enters as carry-in of slice 0
  assign cin  = (cnt_q == '0) ? sub : carry_q;
  assign {co, sum} = {1'b0, b_sl} + {1'b0, sub ? ~a_sl : a_sl} + (CHUNK_W + 1)'(cin);
  assign slice = (ifun_q[1:0] == 2'd2) ? (a_sl & b_sl) : (ifun_q[1:0] == 2'd3) ? (a_sl ^ b_sl) : sum;
  always_comb begin
    full = res_q;
    full[cnt_q*CHUNK_W +: CHUNK_W] = slice;
  end
  assign res_f = bad ? 64'd0 : fast ? (ifun_q[0] ? (a_q ^ b_q) : (a_q & b_q)) : full;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ifun_d  = ifun_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        cnt_d   = '0;
        carry_d = 1'b0;
        ifun_d  = in_ifun;
        a_d     = in_a;
        b_d     = in_b;
        res_d   = '0;
        zf_d    = 1'b0;
        sf_d    = 1'b0;
        of_d    = 1'b0;
        err_d   = 1'b0;
      end
      BUSY: begin
        res_d   = res_f;
        carry_d = co;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          zf_d    = !bad && res_f == 64'd0;
          sf_d    = res_f[63];
          of_d    = add ? (a_q[63] == b_q[63] && res_f[63] != a_q[63]) :
                    sub ? (a_q[63] != b_q[63] && res_f[63] != b_q[63]) : 1'b0;
          err_d   = bad;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ifun_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ifun_q  <= ifun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      err_q   <= err_d;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_result = res_q;
  assign out_zf     = zf_q;
  assign out_sf     = sf_q;
  assign out_of     = of_q;
  assign out_err    = err_q;
endmodule

// File: tb/tb_alu_iter_resp.sv
// tb_alu_iter_resp: directed and random OPq operations checked against a 65-bit arithmetic reference.
module tb_alu_iter_resp;
  localparam int NCHUNK = 4;
`ifdef ALU_FAST_LOGIC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_ifun = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_zf, out_sf, out_of, out_err;
  logic [63:0] out_result;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_iter_resp #(.CHUNK_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ifun(in_ifun),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of), .out_err(out_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b, input int hold);
    logic signed [64:0] w;
    logic [63:0] r, snap;
    logic o;
    int lat, el;
    case (f)
      4'd0: w = {a[63], a} + {b[63], b};
      4'd1: w = {b[63], b} - {a[63], a};
      4'd2: w = {1'b0, a & b};
      4'd3: w = {1'b0, a ^ b};
      default: w = '0;
    endcase
    r = w[63:0];
    o = (f < 4'd2) && (w[64] != w[63]);
    el = (f > 4'd3 || (FAST && (f == 4'd2 || f == 4'd3))) ? 1 : NCHUNK;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_ifun = f; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("result", out_result, r);
    chk("zf", out_zf, f < 4'd4 && r == 0);
    chk("sf", out_sf, r[63]);
    chk("of", out_of, o);
    chk("err", out_err, f > 4'd3);
    snap = out_result;
    repeat (hold) begin
      in_valid = 1'b1; in_ifun = 4'd0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_result", out_result, snap);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask
  initial begin
    int seen;
    logic [63:0] ra, rb;
    logic [63:0] edges [6];
    edges = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_FFFF};
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", {out_zf, out_sf, out_of, out_err}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);
    run(4'd0, 64'h0000_0000_0000_FFFF, 64'h1, 0);
    run(4'd1, 64'd7, 64'd5, 0);
    run(4'd1, 64'd5, 64'd5, 0);
    run(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    run(4'd1, 64'h1, 64'h8000_0000_0000_0000, 0);
    run(4'd3, 64'h13, 64'h0A, 0);
    run(4'd2, 64'hF0F0, 64'hFF00, 5);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("spurious_not_taken", in_ready, 1);
    run(4'd4, 64'h1234, 64'h5678, 1);
    run(4'd15, 64'hFFFF, 64'hFFFF, 0);
    in_valid = 1'b1; in_ifun = 4'd0; in_a = 64'h1111; in_b = 64'h2222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run(4'd0, 64'd3, 64'd4, 0);
    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : {$urandom, $urandom};
      rb = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) rb = ra;
      run(4'($urandom_range(0, 5)), ra, rb, $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
